// File: rtl/mem_store_buffer.sv
// In-order write-back store buffer in front of one SRAM write port.
// Drains the oldest entry on each granted cycle and forwards the youngest matching queued store to loads.
module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          st_valid_i,
    input  logic [AW-1:0] st_addr_i,
    input  logic [DW-1:0] st_data_i,
    output logic          st_ready_o,
    input  logic          port_grant_i,
    output logic          sram_cs_o,
    output logic          sram_we_o,
    output logic          sram_oe_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [DW-1:0] sram_din_o,
    input  logic [AW-1:0] ld_addr_i,
    output logic          ld_hit_o,
    output logic [DW-1:0] ld_data_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    logic [AW-3:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    fwd_idx;
    logic             push, drain;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^{st_addr_i[1:0], ld_addr_i[1:0]};

    assign empty_o    = (count_q == '0);
    assign st_ready_o = (count_q != CW'(DEPTH));
    assign count_o    = count_q;
    assign push       = st_valid_i && st_ready_o;
    assign drain      = !empty_o && port_grant_i;

    // Strobes follow the drain condition directly so an async reset drops them at once.
    assign sram_cs_o   = drain;
    assign sram_we_o   = drain;
    assign sram_oe_o   = 1'b0;
    assign sram_addr_o = empty_o ? '0 : {addr_q[head_q], 2'b00};
    assign sram_din_o  = empty_o ? '0 : data_q[head_q];

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push) - CW'(drain);
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_q] <= st_addr_i[AW-1:2];
            data_q[tail_q] <= st_data_i;
        end
    end

    // Walk oldest to youngest so the last match, nearest tail, wins.
    always_comb begin
        ld_hit_o  = 1'b0;
        ld_data_o = '0;
        fwd_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr_i[AW-1:2])) begin
                ld_hit_o  = 1'b1;
                ld_data_o = data_q[fwd_idx];
            end
        end
    end

endmodule
